// File: rtl/input_buffer.sv
// Memory-mapped I/O load path: synchronises switches/keys, debounces keys, latches press
// events (write-1-to-clear) and serves byte/half/word loads. Define DEBOUNCE_EN to enable counters.
module input_buffer #(
  parameter int SW_WIDTH        = 18,
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [SW_WIDTH-1:0]  i_io_sw,
  input  logic [KEY_WIDTH-1:0] i_io_key,
  input  logic [31:0]          i_io_addr,
  input  logic [2:0]           i_funct3,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [31:0]          i_st_data,
  input  logic                 i_io_valid,
  input  logic                 i_ctrl_kill,
  output logic [31:0]          o_ld_data,
  output logic                 o_ld_valid,
  output logic                 o_key_pending
);

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam logic [3:0] DEV_SW  = 4'h5;
  localparam logic [3:0] DEV_KEY = 4'h6;
  localparam logic [3:0] DEV_EVT = 4'h7;

  logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
  logic [KEY_WIDTH-1:0] key_meta_q, key_sync_q;
  logic [KEY_WIDTH-1:0] pressed_raw;
  logic [KEY_WIDTH-1:0] key_stable_q, key_stable_d;
  logic [KEY_WIDTH-1:0] key_evt_q, key_evt_d;
  logic                 key_pending_q;
  logic [31:0]          ld_data_q, ld_result;
  logic                 ld_valid_q;
  logic                 rd_en, st_en;
  logic [3:0]           dev;
  logic [31:0]          st_mask, st_aligned, clr_word, rd_word;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic                 unused_bits;

  // Keys idle high, so their synchronisers reset to "released".
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '1;
      key_sync_q <= '1;
    end else begin
      sw_meta_q  <= i_io_sw;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= i_io_key;
      key_sync_q <= key_meta_q;
    end
  end

  assign pressed_raw = ~key_sync_q;

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [KEY_WIDTH];
  logic [CNT_W-1:0] cnt_d [KEY_WIDTH];

  always_comb begin
    // NOTE: defaults first so no path through the block leaves a latch.
    key_stable_d = key_stable_q;
    for (int k = 0; k < KEY_WIDTH; k++) begin
      cnt_d[k] = '0;
      if (pressed_raw[k] != key_stable_q[k]) begin
        if (cnt_q[k] == CNT_LAST) key_stable_d[k] = ~key_stable_q[k];
        else                      cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      // NOTE: this array is a handful of flops, not a RAM, so every entry can be reset.
      for (int k = 0; k < KEY_WIDTH; k++) cnt_q[k] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign key_stable_d = pressed_raw;
  assign unused_cfg   = (DEBOUNCE_CYCLES < 2);
`endif

  assign dev   = i_io_addr[15:12];
  assign rd_en = i_mem_read  & i_io_valid & ~i_ctrl_kill;
  assign st_en = i_mem_write & i_io_valid & ~i_ctrl_kill;

  // Store lanes mirror the output-buffer store path so software uses the same idioms.
  always_comb begin
    st_mask    = '0;
    st_aligned = '0;
    case (i_funct3)
      F3_B: begin
        st_mask    = 32'h0000_00FF << {i_io_addr[1:0], 3'b000};
        st_aligned = {24'b0, i_st_data[7:0]} << {i_io_addr[1:0], 3'b000};
      end
      F3_H: begin
        st_mask    = 32'h0000_FFFF << {i_io_addr[1], 4'b0000};
        st_aligned = {16'b0, i_st_data[15:0]} << {i_io_addr[1], 4'b0000};
      end
      F3_W: begin
        st_mask    = '1;
        st_aligned = i_st_data;
      end
      default: ;
    endcase
  end

  assign clr_word  = (st_en && dev == DEV_EVT) ? (st_aligned & st_mask) : '0;
  // A press landing in the same cycle as its clear must not be lost, so set wins.
  assign key_evt_d = (key_evt_q & ~clr_word[KEY_WIDTH-1:0]) | (key_stable_d & ~key_stable_q);

  always_comb begin
    rd_word = '0;
    case (dev)
      DEV_SW:  rd_word = 32'(sw_sync_q);
      DEV_KEY: rd_word = 32'(key_stable_q);
      DEV_EVT: rd_word = 32'(key_evt_q);
      default: ;
    endcase
  end

  assign byte_sel = 8'(rd_word >> {i_io_addr[1:0], 3'b000});
  assign half_sel = 16'(rd_word >> {i_io_addr[1], 4'b0000});

  always_comb begin
    ld_result = '0;
    case (i_funct3)
      F3_B:    ld_result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_result = {24'b0, byte_sel};
      F3_H:    ld_result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_result = {16'b0, half_sel};
      F3_W:    ld_result = rd_word;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      key_stable_q  <= '0;
      key_evt_q     <= '0;
      key_pending_q <= 1'b0;
      ld_data_q     <= '0;
      ld_valid_q    <= 1'b0;
    end else begin
      key_stable_q  <= key_stable_d;
      key_evt_q     <= key_evt_d;
      key_pending_q <= |key_evt_d;
      ld_valid_q    <= rd_en;
      if (rd_en) ld_data_q <= ld_result;
    end
  end

  assign o_ld_data     = ld_data_q;
  assign o_ld_valid    = ld_valid_q;
  assign o_key_pending = key_pending_q;

  assign unused_bits = ^{i_io_addr[31:16], i_io_addr[11:2], clr_word};

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer (DEBOUNCE_CYCLES=4); expectations follow DEBOUNCE_EN when defined.
module tb_input_buffer;

  localparam int SW_W  = 18;
  localparam int KEY_W = 4;
  localparam int DB    = 4;
`ifdef DEBOUNCE_EN
  localparam int SETTLE = 5;
`else
  localparam int SETTLE = 2;
`endif

  logic              clk;
  logic              rst_n;
  logic [SW_W-1:0]   sw;
  logic [KEY_W-1:0]  key;
  logic [31:0]       io_addr;
  logic [2:0]        funct3;
  logic              mem_read, mem_write, io_valid, kill;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic              ld_valid, key_pending;

  int tests = 0;
  int fails = 0;

  input_buffer #(.SW_WIDTH(SW_W), .KEY_WIDTH(KEY_W), .DEBOUNCE_CYCLES(DB)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_io_sw(sw), .i_io_key(key),
    .i_io_addr(io_addr), .i_funct3(funct3), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_st_data(st_data), .i_io_valid(io_valid),
    .i_ctrl_kill(kill), .o_ld_data(ld_data), .o_ld_valid(ld_valid),
    .o_key_pending(key_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] exp, input string tag);
    io_addr = addr; funct3 = f3; mem_read = 1'b1; io_valid = 1'b1;
    @(negedge clk);
    mem_read = 1'b0; io_valid = 1'b0;
    check({tag, " valid"}, 32'(ld_valid), 32'd1);
    check(tag, ld_data, exp);
  endtask

  task automatic store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
    io_addr = addr; funct3 = f3; st_data = data; mem_write = 1'b1; io_valid = 1'b1;
    @(negedge clk);
    mem_write = 1'b0; io_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; key = '1; io_addr = '0; funct3 = 3'b010;
    mem_read = 1'b0; mem_write = 1'b0; io_valid = 1'b0; kill = 1'b0; st_data = '0;

    // Reset state
    wait_n(2);
    check("rst ld_valid", 32'(ld_valid), 32'd0);
    check("rst ld_data", ld_data, 32'h0);
    check("rst pending", 32'(key_pending), 32'd0);
    rst_n = 1'b1;
    load(32'h5000, 3'b010, 32'h0, "LW sw after reset");

    // Switch loads and lane extraction
    sw = 18'h20080;
    wait_n(3);
    load(32'h5000, 3'b000, 32'hFFFF_FF80, "LB 5000");
    load(32'h5000, 3'b100, 32'h0000_0080, "LBU 5000");
    load(32'h5002, 3'b101, 32'h0000_0002, "LHU 5002");
    load(32'h5000, 3'b010, 32'h0002_0080, "LW 5000");
    load(32'h5001, 3'b001, 32'h0000_0080, "LH 5001 offset0 ignored");
    load(32'h5001, 3'b000, 32'h0000_0000, "LB 5001");
    load(32'h5003, 3'b010, 32'h0002_0080, "LW 5003 offset ignored");
    load(32'h5000, 3'b011, 32'h0, "bad funct3 load");
    load(32'h8000, 3'b010, 32'h0, "unmapped device");

    // Short glitch on key[1]
    key = 4'b1101;
    wait_n(3);
    key = 4'b1111;
    wait_n(8);
    load(32'h6000, 3'b010, 32'h0, "stable after glitch");
`ifdef DEBOUNCE_EN
    load(32'h7000, 3'b010, 32'h0, "evt after glitch");
    check("pending after glitch", 32'(key_pending), 32'd0);
`else
    load(32'h7000, 3'b010, 32'h2, "evt after glitch");
    check("pending after glitch", 32'(key_pending), 32'd1);
`endif
    store(32'h7000, 3'b010, 32'hF);
    check("pending after clear all", 32'(key_pending), 32'd0);

    // Held press on key[1]
    key = 4'b1101;
    wait_n(10);
    load(32'h6000, 3'b010, 32'h2, "stable key1");
    load(32'h7000, 3'b010, 32'h2, "evt key1");
    check("pending key1", 32'(key_pending), 32'd1);
    load(32'h7000, 3'b100, 32'h2, "evt reread not cleared");

    // Clear bit1 in the same cycle key[0] becomes stable
    key = 4'b1100;
    wait_n(SETTLE);
    store(32'h7000, 3'b010, 32'h2);
    check("pending after clr+set", 32'(key_pending), 32'd1);
    load(32'h7000, 3'b010, 32'h1, "evt after clr+set");
    load(32'h6000, 3'b010, 32'h3, "stable key0+1");

    // Clears on lanes that miss the event bits
    store(32'h7002, 3'b001, 32'h1);
    load(32'h7000, 3'b010, 32'h1, "SH upper half no clear");
    store(32'h7001, 3'b000, 32'h1);
    load(32'h7000, 3'b010, 32'h1, "SB lane1 no clear");
    store(32'h7000, 3'b011, 32'hF);
    load(32'h7000, 3'b010, 32'h1, "bad funct3 no clear");
    store(32'h7000, 3'b000, 32'h1);
    check("pending after SB clear", 32'(key_pending), 32'd0);
    load(32'h7000, 3'b010, 32'h0, "evt after SB clear");

    // Set wins over clear of the same bit
    key = 4'b0100;
    wait_n(SETTLE);
    store(32'h7000, 3'b010, 32'h8);
    check("pending set wins", 32'(key_pending), 32'd1);
    load(32'h7000, 3'b010, 32'h8, "evt set wins");

    // Read and clear in the same cycle
    io_addr = 32'h7000; funct3 = 3'b010; st_data = 32'h8;
    mem_read = 1'b1; mem_write = 1'b1; io_valid = 1'b1;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; io_valid = 1'b0;
    check("rw valid", 32'(ld_valid), 32'd1);
    check("rw pre-clear data", ld_data, 32'h8);
    check("rw pending", 32'(key_pending), 32'd0);
    load(32'h7000, 3'b010, 32'h0, "evt after rw");

    // Killed and invalid accesses
    key = 4'b0000;
    wait_n(SETTLE + 2);
    load(32'h5000, 3'b010, 32'h0002_0080, "LW before kill");
    kill = 1'b1;
    load_killed: begin
      io_addr = 32'h6000; funct3 = 3'b010; mem_read = 1'b1; io_valid = 1'b1;
      @(negedge clk);
      mem_read = 1'b0;
      check("kill ld_valid", 32'(ld_valid), 32'd0);
      check("kill ld_data held", ld_data, 32'h0002_0080);
      io_addr = 32'h7000; st_data = 32'hF; mem_write = 1'b1;
      @(negedge clk);
      mem_write = 1'b0; io_valid = 1'b0; kill = 1'b0;
      check("kill store pending", 32'(key_pending), 32'd1);
    end
    io_addr = 32'h6000; mem_read = 1'b1; io_valid = 1'b0;
    @(negedge clk);
    mem_read = 1'b0;
    check("io_valid low ld_valid", 32'(ld_valid), 32'd0);
    load(32'h7000, 3'b010, 32'h4, "evt survives kill");

    // Back-to-back loads
    io_addr = 32'h5000; funct3 = 3'b010; mem_read = 1'b1; io_valid = 1'b1;
    @(negedge clk);
    check("b2b first", ld_data, 32'h0002_0080);
    io_addr = 32'h6000; funct3 = 3'b000;
    @(negedge clk);
    check("b2b second valid", 32'(ld_valid), 32'd1);
    check("b2b second", ld_data, 32'h0000_000F);
    mem_read = 1'b0; io_valid = 1'b0;
    @(negedge clk);
    check("valid drops", 32'(ld_valid), 32'd0);
    check("data holds", ld_data, 32'h0000_000F);

    // Reset during an in-flight load
    io_addr = 32'h5000; funct3 = 3'b010; mem_read = 1'b1; io_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst ld_valid", 32'(ld_valid), 32'd0);
    check("midrst ld_data", ld_data, 32'h0);
    check("midrst pending", 32'(key_pending), 32'd0);
    rst_n = 1'b1;
    io_addr = 32'h7000;
    @(negedge clk);
    mem_read = 1'b0; io_valid = 1'b0;
    check("post-rst valid", 32'(ld_valid), 32'd1);
    check("post-rst evt", ld_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
